// File: rtl/hub75_capture.sv
// HUB75 receive-side monitor: rebuilds 12-bit {R,G,B} pixels from BCM bit planes and streams
// each completed row pair as address/data beats. Optional blank-low timing check: BLANK_CHECK_EN.
module hub75_capture #(
  parameter int unsigned NUM_COLS   = 64,
  parameter int unsigned NUM_ROWS   = 64,
  parameter int unsigned BIT_DEPTH  = 4,
  parameter int unsigned INIT_DELAY = 64,
  parameter int unsigned CLK_RATIO  = 4,
  parameter int unsigned BLANK_TOL  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_screen,
  input  logic        R0,
  input  logic        G0,
  input  logic        B0,
  input  logic        R1,
  input  logic        G1,
  input  logic        B1,
  input  logic        latch,
  input  logic        blank,
  input  logic [4:0]  row,
  output logic [11:0] out_data,
  output logic [11:0] out_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err_sync,
  output logic        err_overrun,
  output logic        err_timing
);

  localparam int unsigned CW       = $clog2(NUM_COLS + 1);
  localparam int unsigned IW       = $clog2(NUM_COLS);
  localparam int unsigned PW       = $clog2(BIT_DEPTH + 1);
  localparam int unsigned BW       = $clog2(2 * NUM_COLS);
  localparam int unsigned HALF_OFS = NUM_COLS * NUM_ROWS / 2;

  typedef enum logic [1:0] {StIdle, StSwap, StDrain} drain_st_e;

  // Pin vector: [13:9] row, 8 blank, 7 latch, 6 clk_screen, 5..3 R0/G0/B0, 2..0 R1/G1/B1
  logic [13:0] pins, meta_q, meta_d, sync_q, sync_d;
  logic [2:0]  edge_prev_q, edge_prev_d;
  logic        shift_rise, latch_rise;
  logic [4:0]  row_s;

  logic [CW-1:0] col_q, col_d;
  logic [PW-1:0] plane_q, plane_d, plane_cur, plane_nxt;
  logic [4:0]    last_row_q, last_row_d, drain_row_q, drain_row_d;
  logic          row_valid_q, row_valid_d;
  logic          bank_q, bank_d;
  drain_st_e     st_q, st_d;
  logic [BW-1:0] beat_q, beat_d, rd_beat;
  logic          err_sync_q, err_sync_d, err_overrun_q, err_overrun_d;

  logic [11:0]   up_q [2][NUM_COLS];
  logic [11:0]   dn_q [2][NUM_COLS];
  logic          wr_en;
  logic [IW-1:0] wr_col, rd_col;
  logic [11:0]   up_old, dn_old, up_wr, dn_wr, rd_word;
  logic          drain_bank, dn_half;
  logic [31:0]   addr_full;

  assign pins       = {row, blank, latch, clk_screen, R0, G0, B0, R1, G1, B1};
  assign shift_rise = sync_q[6] & ~edge_prev_q[0];
  assign latch_rise = sync_q[7] & ~edge_prev_q[1];
  assign row_s      = sync_q[13:9];

  // Plane 0 overwrites the entry, so the previous row's bits never leak into a new row.
  assign wr_col = IW'(col_q);
  assign up_old = (plane_q == '0) ? '0 : up_q[bank_q][wr_col];
  assign dn_old = (plane_q == '0) ? '0 : dn_q[bank_q][wr_col];
  assign up_wr  = up_old | ({3'b0, sync_q[5], 3'b0, sync_q[4], 3'b0, sync_q[3]} << plane_q);
  assign dn_wr  = dn_old | ({3'b0, sync_q[2], 3'b0, sync_q[1], 3'b0, sync_q[0]} << plane_q);

  always_comb begin
    meta_d        = pins;
    sync_d        = meta_q;
    edge_prev_d   = sync_q[8:6];
    col_d         = col_q;
    plane_d       = plane_q;
    plane_cur     = plane_q;
    plane_nxt     = plane_q;
    last_row_d    = last_row_q;
    row_valid_d   = row_valid_q;
    bank_d        = bank_q;
    drain_row_d   = drain_row_q;
    st_d          = st_q;
    beat_d        = beat_q;
    err_sync_d    = err_sync_q;
    err_overrun_d = err_overrun_q;
    wr_en         = 1'b0;

    case (st_q)
      StSwap: begin
        st_d   = StDrain;
        beat_d = '0;
      end
      StDrain: begin
        if (out_ready) begin
          if (beat_q == BW'(2 * NUM_COLS - 1)) st_d = StIdle;
          else beat_d = beat_q + BW'(1);
        end
      end
      default: ;
    endcase

    // Shift is handled before a coincident latch so the latch sees the updated column count.
    if (shift_rise) begin
      if (col_q < CW'(NUM_COLS)) begin
        wr_en = 1'b1;
        col_d = col_q + CW'(1);
      end else begin
        row_valid_d = 1'b0;
      end
    end

    if (latch_rise) begin
      if (row_s != last_row_q) begin
        if (plane_q != '0) err_sync_d = 1'b1;
        plane_cur   = '0;
        row_valid_d = 1'b1;
        last_row_d  = row_s;
      end
      if (col_d != CW'(NUM_COLS)) begin
        err_sync_d  = 1'b1;
        row_valid_d = 1'b0;
      end
      col_d     = '0;
      plane_nxt = plane_cur + PW'(1);
      if (plane_nxt == PW'(BIT_DEPTH)) begin
        plane_d = '0;
        if (row_valid_d) begin
          if (st_q == StIdle) begin
            bank_d      = ~bank_q;
            st_d        = StSwap;
            drain_row_d = last_row_d;
          end else begin
            err_overrun_d = 1'b1;
          end
        end
        row_valid_d = 1'b1;
      end else begin
        plane_d = plane_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q        <= '0;
      sync_q        <= '0;
      edge_prev_q   <= '0;
      col_q         <= '0;
      plane_q       <= '0;
      last_row_q    <= '0;
      row_valid_q   <= 1'b1;
      bank_q        <= 1'b0;
      drain_row_q   <= '0;
      st_q          <= StIdle;
      beat_q        <= '0;
      err_sync_q    <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      meta_q        <= meta_d;
      sync_q        <= sync_d;
      edge_prev_q   <= edge_prev_d;
      col_q         <= col_d;
      plane_q       <= plane_d;
      last_row_q    <= last_row_d;
      row_valid_q   <= row_valid_d;
      bank_q        <= bank_d;
      drain_row_q   <= drain_row_d;
      st_q          <= st_d;
      beat_q        <= beat_d;
      err_sync_q    <= err_sync_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      up_q[bank_q][wr_col] <= up_wr;
      dn_q[bank_q][wr_col] <= dn_wr;
    end
  end

  assign drain_bank = ~bank_q;
  assign dn_half    = beat_q >= BW'(NUM_COLS);
  assign rd_beat    = dn_half ? beat_q - BW'(NUM_COLS) : beat_q;
  assign rd_col     = IW'(rd_beat);
  assign rd_word    = dn_half ? dn_q[drain_bank][rd_col] : up_q[drain_bank][rd_col];
  assign addr_full  = 32'(drain_row_q) * 32'(NUM_COLS) + 32'(rd_col) +
                      (dn_half ? 32'(HALF_OFS) : 32'd0);

  assign out_valid   = (st_q == StDrain);
  assign out_data    = out_valid ? rd_word : '0;
  assign out_addr    = out_valid ? addr_full[11:0] : '0;
  assign err_sync    = err_sync_q;
  assign err_overrun = err_overrun_q;

`ifdef BLANK_CHECK_EN
  logic [15:0] blank_cnt_q, blank_cnt_d;
  logic        blank_meas_q, blank_meas_d, err_timing_q, err_timing_d;
  logic        blank_rise, blank_fall;
  logic [31:0] blank_shift, blank_exp, blank_dev;

  assign blank_rise = sync_q[8] & ~edge_prev_q[2];
  assign blank_fall = ~sync_q[8] & edge_prev_q[2];
  // Plane 0 of the counter domain is the last plane of the previous row still on display.
  assign blank_shift = (plane_q == '0) ? 32'(BIT_DEPTH - 1) : 32'(plane_q) - 32'd1;
  assign blank_exp   = (32'(INIT_DELAY) * 32'(CLK_RATIO)) << blank_shift;
  assign blank_dev   = (32'(blank_cnt_q) > blank_exp) ? 32'(blank_cnt_q) - blank_exp
                                                      : blank_exp - 32'(blank_cnt_q);

  always_comb begin
    blank_cnt_d  = blank_cnt_q;
    blank_meas_d = blank_meas_q;
    err_timing_d = err_timing_q;
    if (blank_meas_q && blank_cnt_q != 16'hFFFF) blank_cnt_d = blank_cnt_q + 16'd1;
    if (blank_fall) begin
      blank_meas_d = 1'b1;
      blank_cnt_d  = 16'd1;
    end
    if (blank_rise && blank_meas_q) begin
      blank_meas_d = 1'b0;
      if (blank_dev > 32'(BLANK_TOL)) err_timing_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      blank_cnt_q  <= '0;
      blank_meas_q <= 1'b0;
      err_timing_q <= 1'b0;
    end else begin
      blank_cnt_q  <= blank_cnt_d;
      blank_meas_q <= blank_meas_d;
      err_timing_q <= err_timing_d;
    end
  end

  assign err_timing = err_timing_q;
`else
  logic unused_blank;
  assign unused_blank = ^{edge_prev_q[2], 32'(INIT_DELAY + CLK_RATIO + BLANK_TOL)};
  assign err_timing   = 1'b0;
`endif

endmodule
